// File: rtl/jt12_pcm_feeder_if.sv
// jt12_pcm_feeder_if: DAC write path in, interpolator release bus out
interface jt12_pcm_feeder_if #(parameter int AW = 2);
  logic cen55;
  logic dacen;
  logic dac_wr;
  logic [7:0] dac_din;
  logic pcm_wr;
  logic signed [8:0] pcmin;
  logic [AW:0] level;
  logic ovf;
  modport master(output cen55, dacen, dac_wr, dac_din, input pcm_wr, pcmin, level, ovf);
  modport slave(input cen55, dacen, dac_wr, dac_din, output pcm_wr, pcmin, level, ovf);
endinterface

// File: rtl/jt12_pcm_feeder.sv
// jt12_pcm_feeder: buffers DAC bytes as signed samples and releases one per 55 kHz tick with a held strobe
module jt12_pcm_feeder #(
  parameter int AW = 2,
  parameter int HOLD = 12
) (
  input logic clk,
  input logic rst,
  jt12_pcm_feeder_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  localparam int CW = $clog2(HOLD);
  typedef enum logic {IDLE, STROBE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] level_q, level_d;
  logic ovf_q, ovf_d;
  logic signed [8:0] pcmin_q, pcmin_d;
  logic signed [8:0] mem_q [DEPTH];
  logic signed [8:0] mem_d [DEPTH];
  logic req, full, pop, push;
  always_comb begin
    req = bus.dac_wr & bus.dacen;
    full = level_q == (AW+1)'(DEPTH);
    pop = state_q == IDLE && bus.cen55 && level_q != '0;
    push = req && (!full || pop);
    mem_d = mem_q;
    if (push) mem_d[wp_q] = {~bus.dac_din[7], bus.dac_din[6:0], 1'b0};
    wp_d = bus.dacen ? wp_q + AW'(push) : '0;
    rp_d = bus.dacen ? rp_q + AW'(pop) : '0;
    level_d = bus.dacen ? level_q + (AW+1)'(push) - (AW+1)'(pop) : '0;
    ovf_d = bus.dacen && (ovf_q || (req && full && !pop));
    pcmin_d = pop ? mem_q[rp_q] : pcmin_q;
    cnt_d = pop ? CW'(HOLD - 1) : cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
  end
  always_comb begin
    state_d = state_q == IDLE ? (pop ? STROBE : IDLE) : (cnt_q == '0 ? IDLE : STROBE);
  end
  always_comb begin
    bus.pcm_wr = state_q == STROBE;
    bus.pcmin = pcmin_q;
    bus.level = level_q;
    bus.ovf = ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      level_q <= '0;
      ovf_q <= 1'b0;
      pcmin_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      level_q <= level_d;
      ovf_q <= ovf_d;
      pcmin_q <= pcmin_d;
    end
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_jt12_pcm_feeder.sv
// tb_jt12_pcm_feeder: scoreboard bench for the DAC sample feeder
module tb_jt12_pcm_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int n_rel = 0;
  int hi_cnt = 0;
  int r;
  logic prev_wr = 1'b0;
  int exp_q[$];
  jt12_pcm_feeder_if #(.AW(2)) bus();
  jt12_pcm_feeder #(.AW(2), .HOLD(12)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [7:0] d, input int e);
    bus.dac_din = d;
    bus.dac_wr = 1'b1;
    @(negedge clk);
    bus.dac_wr = 1'b0;
    if (bus.dacen && exp_q.size() < 4) exp_q.push_back(e);
  endtask
  task automatic tick();
    bus.cen55 = 1'b1;
    @(negedge clk);
    bus.cen55 = 1'b0;
  endtask
  task automatic both(input logic [7:0] d, input int e);
    bus.dac_din = d;
    bus.dac_wr = 1'b1;
    bus.cen55 = 1'b1;
    @(negedge clk);
    bus.dac_wr = 1'b0;
    bus.cen55 = 1'b0;
    exp_q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (rst) begin
      prev_wr = 1'b0;
      hi_cnt = 0;
    end else begin
      if (bus.pcm_wr === 1'b1 && !prev_wr) begin
        n_rel++;
        if (exp_q.size() == 0) chk("rel_unexpected", 1, 0);
        else chk("rel_pcmin", int'($signed(bus.pcmin)), exp_q.pop_front());
      end
      if (bus.pcm_wr === 1'b1) hi_cnt++;
      else if (prev_wr) begin
        chk("hold_len", hi_cnt, 12);
        hi_cnt = 0;
      end
      prev_wr = bus.pcm_wr === 1'b1;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    bus.cen55 = 1'b0;
    bus.dacen = 1'b0;
    bus.dac_wr = 1'b0;
    bus.dac_din = 8'h00;
    cyc(2);
    chk("rst_pcm_wr", int'(bus.pcm_wr), 0);
    chk("rst_pcmin", int'($signed(bus.pcmin)), 0);
    chk("rst_level", int'(bus.level), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    rst = 1'b0;
    bus.dacen = 1'b1;
    wr(8'hC0, 128);
    chk("single_lvl1", int'(bus.level), 1);
    tick();
    chk("single_rise", int'(bus.pcm_wr), 1);
    chk("single_lvl0", int'(bus.level), 0);
    chk("single_pcmin", int'($signed(bus.pcmin)), 128);
    cyc(11);
    chk("single_last_hi", int'(bus.pcm_wr), 1);
    cyc(1);
    chk("single_low", int'(bus.pcm_wr), 0);
    wr(8'h00, -256);
    wr(8'h80, 0);
    wr(8'hFF, 254);
    chk("ext_lvl3", int'(bus.level), 3);
    r = n_rel;
    repeat (3) begin
      tick();
      cyc(20);
    end
    chk("ext_releases", n_rel - r, 3);
    chk("ext_lvl0", int'(bus.level), 0);
    r = n_rel;
    both(8'h81, 2);
    cyc(2);
    chk("same_tick_norel", n_rel - r, 0);
    chk("same_tick_lvl", int'(bus.level), 1);
    tick();
    cyc(14);
    chk("same_tick_later", n_rel - r, 1);
    wr(8'h10, -224);
    wr(8'h20, -192);
    wr(8'h30, -160);
    wr(8'h40, -128);
    chk("full_lvl", int'(bus.level), 4);
    chk("full_ovf0", int'(bus.ovf), 0);
    r = n_rel;
    both(8'h60, -64);
    chk("pushpop_lvl", int'(bus.level), 4);
    chk("pushpop_ovf", int'(bus.ovf), 0);
    cyc(14);
    wr(8'h70, -32);
    chk("ovf_set", int'(bus.ovf), 1);
    chk("ovf_lvl", int'(bus.level), 4);
    repeat (4) begin
      tick();
      cyc(14);
    end
    chk("ovf_releases", n_rel - r, 5);
    chk("ovf_drained", int'(bus.level), 0);
    chk("ovf_sticky", int'(bus.ovf), 1);
    chk("ovf_sb_empty", exp_q.size(), 0);
    wr(8'h01, -254);
    wr(8'h02, -252);
    wr(8'h03, -250);
    tick();
    cyc(4);
    bus.dacen = 1'b0;
    cyc(1);
    exp_q.delete();
    chk("dis_lvl", int'(bus.level), 0);
    chk("dis_ovf", int'(bus.ovf), 0);
    chk("dis_still_hi", int'(bus.pcm_wr), 1);
    cyc(12);
    r = n_rel;
    repeat (2) begin
      tick();
      cyc(5);
    end
    wr(8'h90, 32);
    chk("dis_norel", n_rel - r, 0);
    chk("dis_pcmin", int'($signed(bus.pcmin)), -254);
    chk("dis_ignored_wr", int'(bus.level), 0);
    bus.dacen = 1'b1;
    wr(8'hA0, 64);
    wr(8'hB0, 96);
    wr(8'hE0, 192);
    wr(8'hF0, 224);
    wr(8'h11, -222);
    chk("rst_pre_ovf", int'(bus.ovf), 1);
    tick();
    cyc(1);
    rst = 1'b1;
    cyc(1);
    chk("rst_mid_pcm_wr", int'(bus.pcm_wr), 0);
    chk("rst_mid_pcmin", int'($signed(bus.pcmin)), 0);
    chk("rst_mid_level", int'(bus.level), 0);
    chk("rst_mid_ovf", int'(bus.ovf), 0);
    rst = 1'b0;
    exp_q.delete();
    r = n_rel;
    tick();
    cyc(3);
    chk("rst_after_norel", n_rel - r, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
